// File: rtl/i2c_regfile_pkg.sv
// i2c_regfile_pkg: phase encoding and defaults shared by the I2C register-file controller.
package i2c_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PTR  = 2'b01,
        DATA = 2'b10
    } phase_t;

    localparam logic [7:0] RESET_VAL_DEF = 8'h00;

endpackage

// File: rtl/i2c_regfile_mem.sv
// i2c_regfile_mem: register array with one synchronous write/read port and reset init.
module i2c_regfile_mem
    import i2c_regfile_pkg::*;
#(
    parameter int         REG_COUNT = 16,
    parameter int         PTR_W     = 4,
    parameter logic [7:0] RESET_VAL = RESET_VAL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [PTR_W-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= RESET_VAL;
            rdata <= 8'h00;
        end else begin
            if (we) regs[addr] <= wdata;
            if (re) rdata <= regs[addr];
        end
    end

endmodule

// File: rtl/i2c_regfile_ctrl.sv
// i2c_regfile_ctrl: sequences an i2c_slave as a byte-addressed register file shared with a host port.
// Define I2C_REGFILE_WR_IRQ_EN to add the wr_irq/wr_idx write notification outputs.
module i2c_regfile_ctrl
    import i2c_regfile_pkg::*;
#(
    parameter int         REG_COUNT = 16,
    parameter int         PTR_W     = 4,
    parameter logic [7:0] RESET_VAL = RESET_VAL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i2c_busy,
    input  logic             i2c_data_available,
    input  logic             i2c_data_request,
    input  logic [7:0]       i2c_data_o,
    output logic [7:0]       i2c_data_i,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             host_ack,
    output logic [PTR_W-1:0] ptr
`ifdef I2C_REGFILE_WR_IRQ_EN
    ,
    output logic             wr_irq,
    output logic [PTR_W-1:0] wr_idx
`endif
);

    phase_t           phase, phase_nxt;
    logic             busy_q, da_q, dr_q;
    logic             busy_rise, busy_fall, wr_evt, rd_evt;
    logic             wr_evt_d, rd_fetch_d;
    logic             ptr_wr, i2c_wr, i2c_rd, i2c_acc, host_svc;
    logic             mem_we, mem_re;
    logic [PTR_W-1:0] mem_addr;
    logic [7:0]       mem_wdata, mem_rdata;

    // Edge registers keep sampling through reset so a busy line held high is not seen as a new start.
    always_ff @(posedge clk) begin
        busy_q <= i2c_busy;
        da_q   <= i2c_data_available;
        dr_q   <= i2c_data_request;
    end

    assign busy_rise = i2c_busy & ~busy_q;
    assign busy_fall = ~i2c_busy & busy_q;
    assign wr_evt    = i2c_data_available & ~da_q;
    assign rd_evt    = i2c_data_request & ~dr_q;

    always_ff @(posedge clk) begin
        if (rst) phase <= IDLE;
        else     phase <= phase_nxt;
    end

    always_comb begin
        phase_nxt = busy_fall                                  ? IDLE :
                    (phase == IDLE && busy_rise)               ? PTR  :
                    (phase == PTR && (wr_evt_d || rd_evt))     ? DATA :
                    phase;
    end

    always_comb begin
        ptr_wr    = wr_evt_d && phase == PTR;
        i2c_wr    = wr_evt_d && phase == DATA;
        i2c_rd    = rd_evt && phase != IDLE;
        i2c_acc   = i2c_wr || i2c_rd;
        host_svc  = host_req && !i2c_acc && !host_ack;
        mem_we    = i2c_wr || (host_svc && host_we);
        mem_re    = i2c_rd || (host_svc && !host_we);
        mem_addr  = i2c_acc ? ptr : host_addr;
        mem_wdata = i2c_wr ? i2c_data_o : host_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            i2c_data_i <= 8'h00;
            host_ack   <= 1'b0;
            wr_evt_d   <= 1'b0;
            rd_fetch_d <= 1'b0;
        end else begin
            wr_evt_d   <= wr_evt;
            rd_fetch_d <= i2c_rd;
            host_ack   <= host_svc;
            if (rd_fetch_d) i2c_data_i <= mem_rdata;
            if (ptr_wr) ptr <= i2c_data_o[PTR_W-1:0];
            else if (i2c_acc) ptr <= ptr + PTR_W'(1);
        end
    end

    // Read data sits in the memory output register until the next read of either side.
    assign host_rdata = mem_rdata;

    i2c_regfile_mem #(
        .REG_COUNT (REG_COUNT),
        .PTR_W     (PTR_W),
        .RESET_VAL (RESET_VAL)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

`ifdef I2C_REGFILE_WR_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_irq <= 1'b0;
            wr_idx <= '0;
        end else begin
            wr_irq <= i2c_wr;
            if (i2c_wr) wr_idx <= ptr;
        end
    end
`endif

endmodule

// File: doc/i2c_regfile_ctrl.md
Name: i2c_regfile_ctrl

Overview:
- Sequences an i2c_slave instance as a byte-addressed register file.
- First byte written in an I2C transaction sets the register pointer. Later written bytes store to registers; read bytes fetch from registers. The pointer auto-increments after every access.
- A local host port shares the same register array; the arbiter gives the I2C side priority.
- Sits between i2c_slave and system logic (config/status registers).

Parameters:
- REG_COUNT, 16, number of 8-bit registers (power of two, 2..256).
- PTR_W, 4, pointer width = log2(REG_COUNT).
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  in  1  system clock; same clock as i2c_slave.
- rst  in  1  synchronous, active-high reset.
- i2c_busy  in  1  slave busy flag (high from start until stop).
- i2c_data_available  in  1  slave level flag: a written byte is in the ACK phase.
- i2c_data_request  in  1  slave level flag: the slave needs the next read byte.
- i2c_data_o  in  8  byte received by the slave.
- i2c_data_i  out  8  byte for the slave to transmit; registered.
- host_req  in  1  host access request (level, held until ack).
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  PTR_W  host register index.
- host_wdata  in  8  host write data.
- host_rdata  out  8  host read data; valid with host_ack.
- host_ack  out  1  one-cycle completion pulse.
- ptr  out  PTR_W  current I2C register pointer (debug/status).

Behaviour:
- Reset values: all registers = RESET_VAL; ptr = 0; i2c_data_i = 0; host_rdata = 0; host_ack = 0; phase = IDLE.
- Edge detection: i2c_busy, i2c_data_available and i2c_data_request are registered once. Rising edges (wr_evt, rd_evt) are one-cycle pulses. Because both flags are levels, each I2C byte yields exactly one event.
- Write capture: i2c_data_o updates the cycle after data_available rises, so the byte is sampled one cycle after wr_evt (wr_evt_d).
- Phase FSM:
  - IDLE -> PTR on the rising edge of i2c_busy.
  - PTR -> DATA on wr_evt_d: ptr <= i2c_data_o[PTR_W-1:0] (upper bits ignored, i.e. modulo REG_COUNT).
  - PTR -> DATA on rd_evt: the read uses the retained ptr.
  - DATA: wr_evt_d writes reg[ptr] <= i2c_data_o, then ptr <= ptr+1.
  - DATA: rd_evt sets i2c_data_i <= reg[ptr], then ptr <= ptr+1.
  - Any phase -> IDLE when i2c_busy falls.
  - rst forces IDLE from any phase.
- Pointer:
  - Wraps from REG_COUNT-1 to 0.
  - Retained across transactions, so write-pointer + stop + read works.
  - A non-addressed transaction produces no events, so ptr and registers are untouched.
- Read latency: i2c_data_i is valid 2 clk after data_request rises (edge register + fetch). This is well inside the half-SCL ACK window. i2c_data_i holds until the next rd_evt.
- Arbitration:
  - Each cycle, an I2C access (wr_evt_d or rd_evt) takes the register port.
  - A host request is serviced in the first cycle with no I2C access.
  - host_ack pulses in the cycle after service. host_rdata carries reg[host_addr] read at service.
  - Host starvation is bounded: I2C events are at most one per byte time.
- Simultaneous I2C write and host write to the same index: the I2C write lands first; the host write lands in a later cycle and is the final value.
- host_req dropped before ack: the request is abandoned and no ack is issued.
- Reset mid-transaction: phase = IDLE. A new transaction is recognised only on the next busy rising edge; events seen while in IDLE are ignored.

Optional Feature:
- Macro I2C_REGFILE_WR_IRQ_EN.
- Defined: adds outputs wr_irq (1) and wr_idx (PTR_W).
  - wr_irq pulses one cycle after each I2C data-register write (pointer-byte writes excluded).
  - wr_idx holds the written index.
  - Both reset to 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package i2c_regfile_pkg: phase encoding (IDLE=2'b00, PTR=2'b01, DATA=2'b10) and the RESET_VAL default constant.
- Sub-module i2c_regfile_mem: register array with a single synchronous write/read port and reset init. It is driven by the arbiter mux in the top.

Test Plan:
- Reset then idle -> i2c_data_i=0, ptr=0, host reads of regs 0..15 return 8'h00 with one host_ack each.
- I2C write 8'h03, 8'hA5, 8'h5A, then stop -> reg3=A5, reg4=5A, ptr=5, phase IDLE after busy falls.
- Write ptr 8'h0F, stop, then an I2C read of 3 bytes with regs preset F=11, 0=22, 1=33 -> i2c_data_i sequence 11, 22, 33 (wrap); ptr=2.
- Pointer byte 8'hF2 -> ptr=2 (modulo 16).
- host_req write reg2=77 in the same cycle as wr_evt_d to reg2 with data 99 -> host_ack delayed by ≥1 cycle; final reg2=77.
- rst asserted mid-write after 1 data byte -> regs keep reset values; ptr=0; a later write-only transaction behaves as fresh.
- I2C_REGFILE_WR_IRQ_EN defined, write ptr 8'h06 then 8'h10 -> one wr_irq pulse with wr_idx=6; none for the pointer byte.
